// File: rtl/alu_share_arbiter.sv
// Shares one combinational 32-bit ALU between two requesters.
// Each requester gets a one-entry registered response buffer.
// The block also owns the {N,Z,C,V} status register that feeds the ALU carry-in.

// One-entry response buffer.
// Priority on each edge: flush, then load, then consume, otherwise hold.
module alu_share_rsp_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic        rsp_ready,
  input  logic [31:0] load_result,
  input  logic [3:0]  load_status,
  output logic        valid,
  output logic [31:0] result,
  output logic [3:0]  status
);
  logic        valid_q, valid_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  status_q, status_d;

  // Next-state: reload may coincide with consume, giving 1 result/cycle
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    status_d = status_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d  = 1'b1;
      result_d = load_result;
      status_d = load_status;
    end else if (rsp_ready && valid_q) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign valid  = valid_q;
  assign result = result_q;
  assign status = status_q;
endmodule

module alu_share_arbiter #(
  parameter int         FIXED_PRIO = 0,
  parameter logic [3:0] SR_RESET   = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic [3:0]  req0_cmd,
  input  logic        req0_s,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic [3:0]  rsp0_status,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  input  logic [3:0]  req1_cmd,
  input  logic        req1_s,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [3:0]  rsp1_status,
  output logic [3:0]  sr_out
);
  localparam int NUM_REQ = 2;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  logic [NUM_REQ-1:0]        req_valid, req_s, rsp_valid, rsp_ready, elig, grant;
  logic [NUM_REQ-1:0][31:0]  req_in1, req_in2, rsp_result;
  logic [NUM_REQ-1:0][3:0]   req_cmd, rsp_status;

  assign req_valid = {req1_valid, req0_valid};
  assign req_s     = {req1_s, req0_s};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_in1   = {req1_in1, req0_in1};
  assign req_in2   = {req1_in2, req0_in2};
  assign req_cmd   = {req1_cmd, req0_cmd};

  // Index of the most recent grant; reset to 1 so req0 wins first contention
  logic last_grant_q, last_grant_d;
  logic [3:0]  sr_q, sr_d;
  logic [31:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
  logic [3:0]  alu_cmd_q, alu_cmd_d;
  logic        alu_s;
  logic [31:0] alu_res;
  logic [3:0]  alu_status;
  logic [32:0] alu_sum;
  logic        alu_c, alu_v;

  // A requester may be granted only if its buffer is empty or being drained
  assign elig = req_valid & (~rsp_valid | rsp_ready) & {NUM_REQ{~flush}};

  // Grant selection and last-grant tracking
  always_comb begin
    grant        = '0;
    last_grant_d = last_grant_q;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (FIXED_PRIO != 0 || last_grant_q) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
    if (grant[1])      last_grant_d = 1'b1;
    else if (grant[0]) last_grant_d = 1'b0;
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Operand mux; holds the previous selection when idle
  always_comb begin
    alu_in1_d = alu_in1_q;
    alu_in2_d = alu_in2_q;
    alu_cmd_d = alu_cmd_q;
    alu_s     = 1'b0;
    if (grant[0]) begin
      alu_in1_d = req_in1[0];
      alu_in2_d = req_in2[0];
      alu_cmd_d = req_cmd[0];
      alu_s     = req_s[0];
    end else if (grant[1]) begin
      alu_in1_d = req_in1[1];
      alu_in2_d = req_in2[1];
      alu_cmd_d = req_cmd[1];
      alu_s     = req_s[1];
    end
  end

  // Shared ALU; carry-in is the registered SR.C, subtraction carry is ARM-style not-borrow
  always_comb begin
    alu_sum = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_cmd_d)
      CMD_MOV: alu_res = alu_in2_d;
      CMD_ADD, CMD_ADC: begin
        alu_sum = {1'b0, alu_in1_d} + {1'b0, alu_in2_d}
                + {32'd0, (alu_cmd_d == CMD_ADC) & sr_q[1]};
        alu_res = alu_sum[31:0];
        alu_c   = alu_sum[32];
        alu_v   = (alu_in1_d[31] == alu_in2_d[31]) && (alu_res[31] != alu_in1_d[31]);
      end
      CMD_SUB, CMD_SBC: begin
        alu_sum = {1'b0, alu_in1_d} + {1'b0, ~alu_in2_d}
                + {32'd0, (alu_cmd_d == CMD_SUB) | sr_q[1]};
        alu_res = alu_sum[31:0];
        alu_c   = alu_sum[32];
        alu_v   = (alu_in1_d[31] != alu_in2_d[31]) && (alu_res[31] != alu_in1_d[31]);
      end
      CMD_AND: alu_res = alu_in1_d & alu_in2_d;
      CMD_ORR: alu_res = alu_in1_d | alu_in2_d;
      CMD_EOR: alu_res = alu_in1_d ^ alu_in2_d;
      CMD_MVN: alu_res = ~alu_in2_d;
      default: alu_res = '0;
    endcase
    alu_status = {alu_res[31], alu_res == 32'd0, alu_c, alu_v};
  end

  // SR next-state: only a granted op with s set updates it
  always_comb begin
    sr_d = sr_q;
    if ((|grant) && alu_s) sr_d = alu_status;
  end

  // Arbiter, operand-hold and SR registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      sr_q         <= SR_RESET;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_cmd_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      sr_q         <= sr_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_cmd_q    <= alu_cmd_d;
    end
  end

  assign sr_out = sr_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      alu_share_rsp_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .load        (grant[gi]),
        .rsp_ready   (rsp_ready[gi]),
        .load_result (alu_res),
        .load_status (alu_status),
        .valid       (rsp_valid[gi]),
        .result      (rsp_result[gi]),
        .status      (rsp_status[gi])
      );
    end
  endgenerate

  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_result = rsp_result[0];
  assign rsp1_result = rsp_result[1];
  assign rsp0_status = rsp_status[0];
  assign rsp1_status = rsp_status[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: u_rr is round-robin, u_fp is fixed-priority; both share stimulus.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req0_valid, req0_s, rsp0_ready;
  logic [31:0] req0_in1, req0_in2;
  logic [3:0]  req0_cmd;
  logic        req1_valid, req1_s, rsp1_ready;
  logic [31:0] req1_in1, req1_in2;
  logic [3:0]  req1_cmd;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  rsp0_status, rsp1_status, sr_out;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
  logic [31:0] fp_rsp0_result, fp_rsp1_result;
  logic [3:0]  fp_rsp0_status, fp_rsp1_status, fp_sr_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.FIXED_PRIO(0), .SR_RESET(4'b0000)) u_rr (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_cmd(req0_cmd), .req0_s(req0_s),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_status(rsp0_status),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_cmd(req1_cmd), .req1_s(req1_s),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_status(rsp1_status), .sr_out(sr_out)
  );

  alu_share_arbiter #(.FIXED_PRIO(1), .SR_RESET(4'b0000)) u_fp (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_cmd(req0_cmd), .req0_s(req0_s),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(fp_rsp0_result),
    .rsp0_status(fp_rsp0_status),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_cmd(req1_cmd), .req1_s(req1_s),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(fp_rsp1_result),
    .rsp1_status(fp_rsp1_status), .sr_out(fp_sr_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic s);
    req0_valid = v; req0_cmd = c; req0_in1 = a; req0_in2 = b; req0_s = s;
  endtask

  task automatic drv1(input logic v, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic s);
    req1_valid = v; req1_cmd = c; req1_in1 = a; req1_in2 = b; req1_s = s;
  endtask

  // Advance one edge; sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drv0(0, 4'h0, 0, 0, 0);
    drv1(0, 4'h0, 0, 0, 0);
    #1;
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp1_status", {28'd0, rsp1_status}, 0);
    chk("rst_sr", {28'd0, sr_out}, 0);
    tick(); tick();
    rst = 1'b1;

    // single op: ADD 5+7
    drv0(1, 4'b0010, 32'd5, 32'd7, 1);
    #1 chk("add_ready", {31'd0, req0_ready}, 1);
    tick();
    chk("add_rsp_valid", {31'd0, rsp0_valid}, 1);
    chk("add_result", rsp0_result, 32'd12);
    chk("add_status", {28'd0, rsp0_status}, 4'b0000);
    chk("add_sr", {28'd0, sr_out}, 4'b0000);

    // carry chain: FFFFFFFF+1 then ADC 1+1 with C=1
    drv0(0, 4'h0, 0, 0, 0);
    drv1(1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 1);
    #1 chk("carry_ready1", {31'd0, req1_ready}, 1);
    tick();
    chk("carry_result", rsp1_result, 32'd0);
    chk("carry_status", {28'd0, rsp1_status}, 4'b0110);
    chk("carry_sr", {28'd0, sr_out}, 4'b0110);
    drv1(0, 4'h0, 0, 0, 0);
    drv0(1, 4'b0011, 32'd1, 32'd1, 0);
    tick();
    chk("adc_result", rsp0_result, 32'd3);
    chk("adc_status", {28'd0, rsp0_status}, 4'b0000);
    chk("adc_sr_kept", {28'd0, sr_out}, 4'b0110);

    // unsupported command: result 0, Z set, SR updated
    drv0(0, 4'h0, 0, 0, 0);
    drv1(1, 4'b1111, 32'd5, 32'd3, 1);
    tick();
    chk("bad_cmd_result", rsp1_result, 32'd0);
    chk("bad_cmd_status", {28'd0, rsp1_status}, 4'b0100);
    chk("bad_cmd_sr", {28'd0, sr_out}, 4'b0100);

    // overflow, first with s=0 (SR untouched) then s=1
    drv1(0, 4'h0, 0, 0, 0);
    drv0(1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 0);
    tick();
    chk("ovf_result", rsp0_result, 32'h8000_0000);
    chk("ovf_status", {28'd0, rsp0_status}, 4'b1001);
    chk("ovf_s0_sr", {28'd0, sr_out}, 4'b0100);
    drv0(1, 4'b0010, 32'h7FFF_FFFF, 32'd1, 1);
    tick();
    chk("ovf_s1_sr", {28'd0, sr_out}, 4'b1001);
    drv0(0, 4'h0, 0, 0, 0);

    // async reset mid-run restores SR_RESET
    rst = 1'b0;
    #1 chk("rst2_sr", {28'd0, sr_out}, 0);
    tick();
    rst = 1'b1;

    // contention: RR gives 0,1,0,1; fixed priority gives 0,0,0,0
    drv0(1, 4'b0001, 32'd0, 32'h0000_00A5, 0);
    drv1(1, 4'b1000, 32'h0000_00F0, 32'h0000_000F, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_r0_%0d", k), {31'd0, req0_ready}, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_r1_%0d", k), {31'd0, req1_ready}, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("fp_r0_%0d", k), {31'd0, fp_req0_ready}, 1);
      chk($sformatf("fp_r1_%0d", k), {31'd0, fp_req1_ready}, 0);
      tick();
      if (k % 2 == 0) chk($sformatf("rr_res0_%0d", k), rsp0_result, 32'h0000_00A5);
      else            chk($sformatf("rr_res1_%0d", k), rsp1_result, 32'h0000_00FF);
    end

    // backpressure on rsp0
    drv1(0, 4'h0, 0, 0, 0);
    rsp0_ready = 1'b0;
    drv0(1, 4'b0010, 32'd1, 32'd2, 0);
    #1 chk("bp_a_r0", {31'd0, req0_ready}, 1);
    tick();
    chk("bp_a_res", rsp0_result, 32'd3);
    drv0(1, 4'b0010, 32'd3, 32'd4, 0);
    drv1(1, 4'b0110, 32'h0000_00F0, 32'h0000_00FF, 0);
    #1 chk("bp_b_r0", {31'd0, req0_ready}, 0);
    chk("bp_b_r1", {31'd0, req1_ready}, 1);
    tick();
    chk("bp_b_hold", rsp0_result, 32'd3);
    chk("bp_b_res1", rsp1_result, 32'h0000_00F0);
    drv1(1, 4'b0111, 32'd1, 32'd2, 0);
    #1 chk("bp_c_r0", {31'd0, req0_ready}, 0);
    chk("bp_c_r1", {31'd0, req1_ready}, 1);
    tick();
    chk("bp_c_valid0", {31'd0, rsp0_valid}, 1);
    chk("bp_c_hold", rsp0_result, 32'd3);
    chk("bp_c_res1", rsp1_result, 32'd3);
    rsp0_ready = 1'b1;
    #1 chk("bp_d_r0", {31'd0, req0_ready}, 1);
    chk("bp_d_r1", {31'd0, req1_ready}, 0);
    tick();
    chk("bp_d_res0", rsp0_result, 32'd7);
    chk("bp_d_valid1", {31'd0, rsp1_valid}, 0);

    // fill both buffers, set SR, then flush
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    drv0(0, 4'h0, 0, 0, 0);
    drv1(1, 4'b1001, 32'd0, 32'd0, 1);
    tick();
    chk("mvn_result", rsp1_result, 32'hFFFF_FFFF);
    chk("mvn_sr", {28'd0, sr_out}, 4'b1000);
    chk("fill_v0", {31'd0, rsp0_valid}, 1);
    chk("fill_v1", {31'd0, rsp1_valid}, 1);
    flush = 1'b1;
    drv0(1, 4'b0010, 32'd1, 32'd1, 1);
    drv1(1, 4'b0010, 32'd1, 32'd1, 1);
    #1 chk("flush_r0", {31'd0, req0_ready}, 0);
    chk("flush_r1", {31'd0, req1_ready}, 0);
    tick();
    chk("flush_v0", {31'd0, rsp0_valid}, 0);
    chk("flush_v1", {31'd0, rsp1_valid}, 0);
    chk("flush_sr", {28'd0, sr_out}, 4'b1000);
    flush = 1'b0;

    // reset with a full buffer: outputs clear immediately
    drv1(0, 4'h0, 0, 0, 0);
    drv0(1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 1);
    tick();
    chk("pre_rst_v0", {31'd0, rsp0_valid}, 1);
    chk("pre_rst_sr", {28'd0, sr_out}, 4'b0110);
    drv0(0, 4'h0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("rst3_v0", {31'd0, rsp0_valid}, 0);
    chk("rst3_result", rsp0_result, 0);
    chk("rst3_status", {28'd0, rsp0_status}, 0);
    chk("rst3_sr", {28'd0, sr_out}, 0);
    tick();
    rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
